// File: rtl/serial_load_ctrl_pkg.sv
// Shared types and frame sizing for the serial load controller.
// Define SERIAL_PARITY_EN to append an even-parity bit to every frame.
package serial_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t;

   localparam int SER_WIDTH = 5;

   function automatic int frame_len(input int width);
`ifdef SERIAL_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/serial_load_ctrl_if.sv
// Parallel-word valid/ready handshake into the serial load controller.
// The word width tracks the controller WIDTH parameter.
interface serial_load_ctrl_if
   import serial_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH
);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );

endinterface

// File: rtl/serial_load_ctrl_frame_counter.sv
// Mod-N frame bit counter with synchronous active-low clear,
// load-zero and a terminal-count flag at N-1.
module frame_counter
   import serial_pkg::*;
#(
   parameter int N = SER_WIDTH
) (
   input  logic clk,
   input  logic clr,
   input  logic load_zero,
   input  logic en,
   output logic tc
);

   localparam int W = $clog2(N + 1);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   assign tc = (cnt_q == W'(N - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (load_zero) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_load_ctrl.sv
// Serialises a handshaked parallel word onto D/E for a shift register.
// Define SERIAL_PARITY_EN to append an even-parity bit to every frame.
module serial_load_ctrl
   import serial_pkg::*;
#(
   parameter int WIDTH     = SER_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic               clk,
   input  logic               clr,
   serial_load_ctrl_if.slave  in_if,
   output logic               D,
   output logic               E,
   output logic               busy,
   output logic               done
);

   localparam int FL = frame_len(WIDTH);

   ser_state_t    state_d;
   ser_state_t    state_q;
   logic [FL-1:0] sreg_d;
   logic [FL-1:0] sreg_q;
   logic [FL-1:0] load_w;
   logic [FL-1:0] shft_w;
   logic          e_d;
   logic          e_q;
   logic          done_d;
   logic          done_q;
   logic          hs;
   logic          cnt_ld;
   logic          cnt_en;
   logic          cnt_tc;

   // Zeros shift in behind the head, so D is a plain flop output
   // and idles low once the frame has drained.
   if (MSB_FIRST) begin : g_msb
`ifdef SERIAL_PARITY_EN
      assign load_w = {in_if.in_data, ^in_if.in_data};
`else
      assign load_w = in_if.in_data;
`endif
      assign shft_w = {sreg_q[FL-2:0], 1'b0};
      assign D      = sreg_q[FL-1];
   end else begin : g_lsb
`ifdef SERIAL_PARITY_EN
      assign load_w = {^in_if.in_data, in_if.in_data};
`else
      assign load_w = in_if.in_data;
`endif
      assign shft_w = {1'b0, sreg_q[FL-1:1]};
      assign D      = sreg_q[0];
   end

   assign in_if.in_ready = (state_q == IDLE) & clr;
   assign hs             = in_if.in_valid & in_if.in_ready;
   assign E              = e_q;
   assign done           = done_q;
   assign busy           = (state_q != IDLE);

   frame_counter #(
      .N (FL)
   ) u_cnt (
      .clk       (clk),
      .clr       (clr),
      .load_zero (cnt_ld),
      .en        (cnt_en),
      .tc        (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_ld  = 1'b0;
      cnt_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (hs) begin
               sreg_d  = load_w;
               cnt_ld  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sreg_d = shft_w;
            cnt_en = 1'b1;
            if (cnt_tc) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      e_d    = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         e_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         e_q     <= e_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Bench for serial_load_ctrl: MSB-first and LSB-first instances side by side.
// Honours SERIAL_PARITY_EN when compiled with it.
module tb_serial_load_ctrl;

`ifdef SERIAL_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int W  = 5;
   localparam int FL = W + PAR;

   logic clk = 1'b0;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   serial_load_ctrl_if #(.WIDTH(W)) a_if ();
   serial_load_ctrl_if #(.WIDTH(W)) b_if ();

   logic a_d, a_e, a_busy, a_done;
   logic b_d, b_e, b_busy, b_done;

   serial_load_ctrl #(
      .WIDTH     (W),
      .MSB_FIRST (1'b1)
   ) dut_a (
      .clk   (clk),
      .clr   (clr),
      .in_if (a_if),
      .D     (a_d),
      .E     (a_e),
      .busy  (a_busy),
      .done  (a_done)
   );

   serial_load_ctrl #(
      .WIDTH     (W),
      .MSB_FIRST (1'b0)
   ) dut_b (
      .clk   (clk),
      .clr   (clr),
      .in_if (b_if),
      .D     (b_d),
      .E     (b_e),
      .busy  (b_busy),
      .done  (b_done)
   );

   int nvec = 0;
   int nerr = 0;
   int ncyc = 0;
   int rises[$];
   logic e_prev = 1'b0;

   // Reference: pos = -1 idle, 0..FL-1 frame bit on the wire, FL done.
   int pos = -1;
   bit fa[FL];
   bit fb[FL];

   typedef struct {
      bit         c;
      bit         v;
      logic [4:0] dat;
      bit         e;
      bit         da;
      bit         db;
      bit         dn;
      bit         rdy;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, ncyc, act, exp);
      end
   endtask

   task automatic model_edge(input bit c, input bit v, input logic [W-1:0] dat);
      if (!c) begin
         pos = -1;
      end else if (pos < 0) begin
         if (v) begin
            for (int i = 0; i < W; i++) begin
               fa[i] = dat[W-1-i];
               fb[i] = dat[i];
            end
            if (PAR != 0) begin
               fa[FL-1] = ^dat;
               fb[FL-1] = ^dat;
            end
            pos = 0;
         end
      end else if (pos < FL) begin
         pos++;
      end else begin
         pos = -1;
      end
   endtask

   task automatic drive(input bit c, input bit v, input logic [W-1:0] dat);
      clr           = c;
      a_if.in_valid = v;
      a_if.in_data  = dat;
      b_if.in_valid = v;
      b_if.in_data  = dat;
      @(posedge clk);
      model_edge(c, v, dat);
      #1;
      ncyc++;
   endtask

   task automatic track();
      if (a_e && !e_prev) rises.push_back(ncyc);
      e_prev = a_e;
   endtask

   task automatic check_model();
      bit e;
      bit da;
      bit db;
      e  = (pos >= 0) && (pos < FL);
      da = 1'b0;
      db = 1'b0;
      if (e) begin
         da = fa[pos];
         db = fb[pos];
      end
      chk("E_msb", int'(a_e), int'(e));
      chk("E_lsb", int'(b_e), int'(e));
      chk("D_msb", int'(a_d), int'(da));
      chk("D_lsb", int'(b_d), int'(db));
      chk("done_msb", int'(a_done), int'(pos == FL));
      chk("done_lsb", int'(b_done), int'(pos == FL));
      chk("busy_msb", int'(a_busy), int'(pos >= 0));
      chk("busy_lsb", int'(b_busy), int'(pos >= 0));
      chk("ready_msb", int'(a_if.in_ready), int'((pos < 0) && clr));
      chk("ready_lsb", int'(b_if.in_ready), int'((pos < 0) && clr));
      track();
   endtask

   task automatic cyc(input bit c, input bit v, input logic [W-1:0] dat);
      drive(c, v, dat);
      check_model();
   endtask

   initial begin
      a_if.in_valid = 1'b0;
      a_if.in_data  = '0;
      b_if.in_valid = 1'b0;
      b_if.in_data  = '0;

      // 10110: MSB order 1,0,1,1,0 ; LSB order 0,1,1,0,1 ; parity 1
      tbl.push_back('{1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 1'b1, 5'b10110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      if (PAR != 0)
         tbl.push_back('{1'b1, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].c, tbl[i].v, tbl[i].dat);
         chk("tbl_E", int'(a_e), int'(tbl[i].e));
         chk("tbl_D_msb", int'(a_d), int'(tbl[i].da));
         chk("tbl_D_lsb", int'(b_d), int'(tbl[i].db));
         chk("tbl_done", int'(a_done), int'(tbl[i].dn));
         chk("tbl_ready", int'(a_if.in_ready), int'(tbl[i].rdy));
         track();
      end

      // LSB-first word 00011 -> 1,1,0,0,0 on dut_b
      cyc(1'b1, 1'b1, 5'b00011);
      repeat (FL + 3) cyc(1'b1, 1'b0, 5'b00000);

      // back-to-back with valid held high
      rises.delete();
      cyc(1'b1, 1'b1, 5'b11111);
      repeat (FL + 2) cyc(1'b1, 1'b1, 5'b00001);
      repeat (FL + 3) cyc(1'b1, 1'b0, 5'b00000);
      if (rises.size() >= 2) begin
         chk("b2b_spacing", rises[1] - rises[0], FL + 2);
      end else begin
         chk("b2b_frames", rises.size(), 2);
      end

      // reset during the third SHIFT cycle of 10101
      cyc(1'b1, 1'b1, 5'b10101);
      cyc(1'b1, 1'b0, 5'b00000);
      cyc(1'b1, 1'b0, 5'b00000);
      cyc(1'b0, 1'b0, 5'b00000);
      chk("rst_E_drop", int'(a_e), 0);
      cyc(1'b0, 1'b1, 5'b11111);
      cyc(1'b1, 1'b0, 5'b00000);
      chk("rst_ready_back", int'(a_if.in_ready), 1);
      cyc(1'b1, 1'b1, 5'b01010);
      repeat (FL + 3) cyc(1'b1, 1'b0, 5'b00000);

      // in_data changes mid-frame must not disturb the captured word
      cyc(1'b1, 1'b1, 5'b10000);
      repeat (FL) cyc(1'b1, 1'b0, 5'b01111);
      repeat (3) cyc(1'b1, 1'b0, 5'b00000);

      // all-zero word: frame and parity bit stay low
      cyc(1'b1, 1'b1, 5'b00000);
      repeat (FL + 3) cyc(1'b1, 1'b0, 5'b00000);

      // random traffic with occasional resets
      repeat (600) begin
         cyc(bit'($urandom_range(39) != 0),
             bit'($urandom_range(1)),
             W'($urandom));
      end
      repeat (FL + 3) cyc(1'b1, 1'b0, 5'b00000);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
